cpu_sequencer: RTL
==================

# cpu_sequencer

Architectural state holder and clock-enable sequencer for the 8-bit multi-cycle CPU. It owns the FSM state register, instruction register, zero flag and halt latch. It feeds `state`, `instr` and `zf` to the combinational control unit and consumes that unit's `next_state`, `ir_we`, `zf_we` and `halt`. It adds a single-step debug mode and retire/cycle counters, and exports an `advance` enable that the datapath ANDs into every write enable.

## Interface
- `CNT_W`, default 16: width of the cycle and retire counters.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `next_state` input 3: next FSM state from the control unit.
- `ir_we` input 1: load the instruction register from `mem_rdata`.
- `zf_we` input 1: load the zero flag from `alu_zero`.
- `halt` input 1: halt request from the control unit.
- `mem_rdata` input 8: instruction memory read data.
- `alu_zero` input 1: ALU result == 0.
- `step_mode` input 1: 1 = single-step, 0 = free run.
- `step_req` input 1: step request level; its rising edge launches one instruction.
- `state` output 3: current FSM state to the control unit.
- `instr` output 8: instruction register.
- `zf` output 1: zero flag.
- `advance` output 1: this cycle commits; gates all datapath write enables.
- `halted` output 1: sticky halt indicator.
- `illegal` output 1: sticky flag, unencoded `next_state` seen.
- `step_ack` output 1: one-cycle pulse, stepped instruction retired.
- `cycle_count` output CNT_W: number of advancing cycles.
- `retire_count` output CNT_W: number of retired instructions.

## Operation
- State encoding: FETCH=000, DECODE=001, EXECUTE=010, MEMORY=011, WRITEBACK=100, HALT_STATE=101.
- Step edge detect: `step_req_q` is a registered copy of `step_req`. `step_pulse = step_req & ~step_req_q`.
- `advance` is combinational: `advance = !halted && (!step_mode || state != FETCH || step_pulse)`.
- On a clock edge with `advance=1`:
  - `state <= next_state`.
  - If `ir_we`: `instr <= mem_rdata`.
  - If `zf_we`: `zf <= alu_zero`.
  - `cycle_count` increments; it wraps from all-ones to 0.
- On a clock edge with `advance=0`, every register except `step_req_q` holds.
- Retire: an advancing edge with `state != FETCH` and `next_state == FETCH`. On retire:
  - `retire_count` increments; it wraps.
  - If `step_mode=1`, `step_ack` pulses high for the following cycle.
- Halt: an advancing edge with `halt=1` or `next_state == HALT_STATE` sets `state=HALT_STATE` and `halted=1`. Both are sticky until reset. `advance` is 0 from then on.
- Illegal: an advancing edge with `next_state` = 110 or 111 forces `state=HALT_STATE`, `halted=1` and `illegal=1`.
- `step_mode` changes take effect only while `state == FETCH`. A step already in flight always completes to FETCH.
- A `step_req` held high launches exactly one instruction. Re-arming requires a low then a high level.
- Reset, asynchronous and valid in any state including mid-instruction:
  - `state`=FETCH, `instr`=0x00, `zf`=0.
  - `halted`=0, `illegal`=0, `step_ack`=0, `step_req_q`=0.
  - Both counters = 0.
  - `advance` therefore returns to 1 in run mode.

## Timing
- Every output except `advance` is registered and changes only on a rising `clk` edge or on `reset` assertion.
- `advance` depends combinationally on `state`, `halted`, `step_mode` and `step_req`; it has no path from `next_state`.
- Instruction latency in run mode:
  - ALU ops (FETCH→DECODE→EXECUTE→WRITEBACK): 4 cycles.
  - JUMP / JUMPz (FETCH→DECODE→EXECUTE→FETCH): 3 cycles.
  - Memory ops through MEMORY: 4–5 cycles, per the control unit.
- `step_ack` asserts the cycle after the retiring edge and lasts exactly 1 cycle.
- `zf` written in EXECUTE is visible to the control unit from the next state onward. A JUMPz therefore sees the flag from the prior ALU instruction.
- Simultaneous `halt=1` and retire: halt wins, `state`=HALT_STATE, and `retire_count` still increments.

## Test plan
- Reset, run mode, ADD B,A,B (0x14) on `mem_rdata`, control unit in loop:
  - State sequence 000→001→010→100→000.
  - `instr`=0x14, `retire_count`=1 and `cycle_count`=4 after 4 edges.
- ALU with `alu_zero=1`, `zf_we=1` in EXECUTE, then JUMPz B,3 (0xD3): `zf`=1 at the JUMPz EXECUTE, and the JUMP retires in 3 cycles.
- `step_mode=1`, `step_req` low:
  - State stays FETCH, `advance`=0 and counters frozen for 10 cycles.
  - Raise `step_req` and hold it: exactly one instruction runs, `step_ack` is a single 1-cycle pulse, and the sequencer returns to a FETCH stall.
- Force `next_state`=111 in DECODE:
  - `state`=101, `halted`=1, `illegal`=1.
  - `advance`=0 thereafter and counters unchanged for 10 cycles.
- Assert `reset` asynchronously mid-EXECUTE (between edges):
  - All outputs take their reset values immediately.
  - After release, fetch resumes from FETCH with `cycle_count` starting at 0.
- Preload `cycle_count` near wrap (`CNT_W`=4) and run 20 cycles: the count wraps 15→0 and the retire count stays consistent.

Source files
------------

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : State register, IR, zero flag and halt latch for the 8-bit
//               multi-cycle CPU, with single-step control and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       next_state,
  input  logic             ir_we,
  input  logic             zf_we,
  input  logic             halt,
  input  logic [7:0]       mem_rdata,
  input  logic             alu_zero,
  input  logic             step_mode,
  input  logic             step_req,
  output logic [2:0]       state,
  output logic [7:0]       instr,
  output logic             zf,
  output logic             advance,
  output logic             halted,
  output logic             illegal,
  output logic             step_ack,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [2:0] {
    FETCH      = 3'b000,
    DECODE     = 3'b001,
    EXECUTE    = 3'b010,
    MEMORY     = 3'b011,
    WRITEBACK  = 3'b100,
    HALT_STATE = 3'b101
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_halted, w_halted_nxt;
  logic             r_illegal, w_illegal_nxt;
  logic [7:0]       r_instr;
  logic             r_zf;
  logic             r_step_ack;
  logic             r_step_req_q;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_retire_count;

  logic w_step_pulse;
  logic w_advance;
  logic w_illegal_ns;
  logic w_retire;

  assign w_step_pulse = step_req & ~r_step_req_q;
  // In step mode only the FETCH stall waits for a step edge; an instruction
  // already in flight always runs through to the next FETCH.
  assign w_advance    = !r_halted && (!step_mode || (r_state != FETCH) || w_step_pulse);
  assign w_illegal_ns = (next_state[2:1] == 2'b11);
  assign w_retire     = (r_state != FETCH) && (next_state == FETCH);

  always_comb begin
    w_state_nxt   = r_state;
    w_halted_nxt  = r_halted;
    w_illegal_nxt = r_illegal;
    if (w_advance) begin
      if (w_illegal_ns) begin
        w_state_nxt   = HALT_STATE;
        w_halted_nxt  = 1'b1;
        w_illegal_nxt = 1'b1;
      end else if (halt || (next_state == HALT_STATE)) begin
        w_state_nxt  = HALT_STATE;
        w_halted_nxt = 1'b1;
      end else begin
        w_state_nxt = state_t'(next_state);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_halted  <= w_halted_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr        <= 8'h00;
      r_zf           <= 1'b0;
      r_step_ack     <= 1'b0;
      r_step_req_q   <= 1'b0;
      r_cycle_count  <= '0;
      r_retire_count <= '0;
    end else begin
      r_step_req_q <= step_req;
      // Ack is a pulse, so it clears on stalled cycles rather than holding.
      r_step_ack   <= w_advance && w_retire && step_mode;
      if (w_advance) begin
        if (ir_we) r_instr <= mem_rdata;
        if (zf_we) r_zf    <= alu_zero;
        r_cycle_count <= r_cycle_count + CNT_W'(1);
        if (w_retire) r_retire_count <= r_retire_count + CNT_W'(1);
      end
    end
  end

  assign state        = r_state;
  assign instr        = r_instr;
  assign zf           = r_zf;
  assign advance      = w_advance;
  assign halted       = r_halted;
  assign illegal      = r_illegal;
  assign step_ack     = r_step_ack;
  assign cycle_count  = r_cycle_count;
  assign retire_count = r_retire_count;

endmodule
`default_nettype wire
